// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the RV32I execute stage.
// Instruction-type encodings match the decoder's 6-bit inst_type bus.
package ex_stage_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int TYPE_W  = 6;
    localparam int STALL_W = 6;

    localparam logic STOP          = 1'b1;
    localparam logic NOT_STOP      = 1'b0;
    localparam logic BRANCH        = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [TYPE_W-1:0] {
        T_NOP = 6'd0, T_LUI, T_AUIPC, T_JAL, T_JALR,
        T_BEQ, T_BNE, T_BLT, T_BGE, T_BLTU, T_BGEU,
        T_LB, T_LH, T_LW, T_LBU, T_LHU,
        T_SB, T_SH, T_SW,
        T_ADDI, T_SLTI, T_SLTIU, T_XORI, T_ORI, T_ANDI,
        T_SLLI, T_SRLI, T_SRAI,
        T_ADD, T_SUB, T_SLL, T_SLT, T_SLTU,
        T_XOR, T_SRL, T_SRA, T_OR, T_AND
    } inst_type_e;

    typedef struct packed {
        logic              rd;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   rd_val;
        logic [TYPE_W-1:0] inst_type;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN-1:0]   mem_wdata;
        logic              bp_valid;
        logic [XLEN-1:0]   bp_pc;
        logic              bp_taken;
    } ex_mem_t;

    function automatic logic is_cond_branch(input logic [TYPE_W-1:0] t);
        return (t >= T_BEQ) && (t <= T_BGEU);
    endfunction

    function automatic logic is_load(input logic [TYPE_W-1:0] t);
        return (t >= T_LB) && (t <= T_LHU);
    endfunction

    function automatic logic is_store(input logic [TYPE_W-1:0] t);
        return (t >= T_SB) && (t <= T_SW);
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: result value, branch decision and branch target.
// Loads/stores return their effective address as the result.
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [TYPE_W-1:0] inst_type_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic [XLEN-1:0]   result_o,
    output logic              taken_o,
    output logic [XLEN-1:0]   target_o
);

    logic [4:0]      shamt_r;
    logic [4:0]      shamt_i;
    logic [XLEN-1:0] addr_sum;

    assign shamt_r  = rs2_i[4:0];
    assign shamt_i  = imm_i[4:0];
    assign addr_sum = rs1_i + imm_i;

    always_comb begin
        result_o = '0;
        taken_o  = 1'b0;
        target_o = pc_i + imm_i;
        case (inst_type_i)
            T_LUI:   result_o = imm_i;
            T_AUIPC: result_o = pc_i + imm_i;
            T_JAL: begin
                result_o = pc_i + 32'd4;
                taken_o  = BRANCH;
            end
            T_JALR: begin
                result_o = pc_i + 32'd4;
                taken_o  = BRANCH;
                target_o = addr_sum & ~32'd1;
            end
            T_BEQ:  taken_o = (rs1_i == rs2_i);
            T_BNE:  taken_o = (rs1_i != rs2_i);
            T_BLT:  taken_o = ($signed(rs1_i) < $signed(rs2_i));
            T_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            T_BLTU: taken_o = (rs1_i < rs2_i);
            T_BGEU: taken_o = (rs1_i >= rs2_i);
            T_LB, T_LH, T_LW, T_LBU, T_LHU,
            T_SB, T_SH, T_SW,
            T_ADDI: result_o = addr_sum;
            T_SLTI:  result_o = {31'd0, $signed(rs1_i) < $signed(imm_i)};
            T_SLTIU: result_o = {31'd0, rs1_i < imm_i};
            T_XORI:  result_o = rs1_i ^ imm_i;
            T_ORI:   result_o = rs1_i | imm_i;
            T_ANDI:  result_o = rs1_i & imm_i;
            T_SLLI:  result_o = rs1_i << shamt_i;
            T_SRLI:  result_o = rs1_i >> shamt_i;
            T_SRAI:  result_o = $unsigned($signed(rs1_i) >>> shamt_i);
            T_ADD:   result_o = rs1_i + rs2_i;
            T_SUB:   result_o = rs1_i - rs2_i;
            T_SLL:   result_o = rs1_i << shamt_r;
            T_SLT:   result_o = {31'd0, $signed(rs1_i) < $signed(rs2_i)};
            T_SLTU:  result_o = {31'd0, rs1_i < rs2_i};
            T_XOR:   result_o = rs1_i ^ rs2_i;
            T_SRL:   result_o = rs1_i >> shamt_r;
            T_SRA:   result_o = $unsigned($signed(rs1_i) >>> shamt_r);
            T_OR:    result_o = rs1_i | rs2_i;
            T_AND:   result_o = rs1_i & rs2_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch resolution, forwarding, EX/MEM register.
// A mispredicting instruction still advances; younger stages are flushed upstream.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic [STALL_W-1:0]  stall,
    input  logic [XLEN-1:0]     rs1_val_in,
    input  logic [XLEN-1:0]     rs2_val_in,
    input  logic                rd_in,
    input  logic [REG_AW-1:0]   rd_addr_in,
    input  logic [TYPE_W-1:0]   inst_type_in,
    input  logic [XLEN-1:0]     imm_in,
    input  logic [XLEN-1:0]     pc_in,
    input  logic                loading_in,
    input  logic                pre_to_take_in,
    output logic                branch_flag_out,
    output logic [XLEN-1:0]     branch_target_out,
    output logic                fwd_we_out,
    output logic [REG_AW-1:0]   fwd_addr_out,
    output logic [XLEN-1:0]     fwd_data_out,
    output logic                ex_loading_out,
    output logic                rd_mem_out,
    output logic [REG_AW-1:0]   rd_addr_mem_out,
    output logic [XLEN-1:0]     rd_val_mem_out,
    output logic [TYPE_W-1:0]   inst_type_mem_out,
    output logic [XLEN-1:0]     mem_addr_mem_out,
    output logic [XLEN-1:0]     mem_wdata_mem_out,
    output logic                bp_upd_valid_out,
    output logic [XLEN-1:0]     bp_upd_pc_out,
    output logic                bp_upd_taken_out
);

    localparam ex_mem_t EX_MEM_RST = '{
        rd:        WRITE_DISABLE,
        rd_addr:   '0,
        rd_val:    '0,
        inst_type: T_NOP,
        mem_addr:  '0,
        mem_wdata: '0,
        bp_valid:  1'b0,
        bp_pc:     RESET_PC,
        bp_taken:  1'b0
    };

    logic [XLEN-1:0] result;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            mispredict;
    logic            is_mem;
    ex_mem_t         mem_d;
    ex_mem_t         mem_q;
    logic            unused_stall;

    assign unused_stall = ^{stall[5], stall[2:0]};

    ex_alu u_alu (
        .inst_type_i (inst_type_in),
        .rs1_i       (rs1_val_in),
        .rs2_i       (rs2_val_in),
        .imm_i       (imm_in),
        .pc_i        (pc_in),
        .result_o    (result),
        .taken_o     (taken),
        .target_o    (target)
    );

    assign is_mem = is_load(inst_type_in) || is_store(inst_type_in);

    always_comb begin
        mispredict = (inst_type_in == T_JALR) ||
                     (((inst_type_in == T_JAL) || is_cond_branch(inst_type_in)) &&
                      (taken != pre_to_take_in));
        branch_flag_out = mispredict && !rst_in && rdy_in &&
                          (stall[3] == NOT_STOP) && (inst_type_in != T_NOP);
        branch_target_out = RESET_PC;
        if (branch_flag_out)
            branch_target_out = taken ? target : pc_in + 32'd4;
    end

    assign fwd_we_out     = rd_in && (rd_addr_in != '0) && !loading_in;
    assign fwd_addr_out   = rd_addr_in;
    assign fwd_data_out   = result;
    assign ex_loading_out = loading_in;

    always_comb begin
        mem_d = mem_q;
        if (!rdy_in) begin
            mem_d = mem_q;
        end else if (stall[3] == STOP && stall[4] == NOT_STOP) begin
            mem_d = EX_MEM_RST;
        end else if (stall[3] == STOP) begin
            mem_d = mem_q;
        end else begin
            mem_d.rd        = rd_in;
            mem_d.rd_addr   = rd_addr_in;
            mem_d.rd_val    = result;
            mem_d.inst_type = inst_type_in;
            mem_d.mem_addr  = is_mem ? result : '0;
            mem_d.mem_wdata = is_store(inst_type_in) ? rs2_val_in : '0;
            mem_d.bp_valid  = (inst_type_in == T_JAL) || is_cond_branch(inst_type_in);
            mem_d.bp_pc     = pc_in;
            mem_d.bp_taken  = taken;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            mem_q <= EX_MEM_RST;
        else
            mem_q <= mem_d;
    end

    assign rd_mem_out        = mem_q.rd;
    assign rd_addr_mem_out   = mem_q.rd_addr;
    assign rd_val_mem_out    = mem_q.rd_val;
    assign inst_type_mem_out = mem_q.inst_type;
    assign mem_addr_mem_out  = mem_q.mem_addr;
    assign mem_wdata_mem_out = mem_q.mem_wdata;
    assign bp_upd_valid_out  = mem_q.bp_valid;
    assign bp_upd_pc_out     = mem_q.bp_pc;
    assign bp_upd_taken_out  = mem_q.bp_taken;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against a behavioural model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0400;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rd_in, loading_in, pre_to_take_in;
    logic [5:0]  stall, inst_type_in;
    logic [31:0] rs1_val_in, rs2_val_in, imm_in, pc_in;
    logic [4:0]  rd_addr_in;
    logic        branch_flag_out, fwd_we_out, ex_loading_out;
    logic [31:0] branch_target_out, fwd_data_out;
    logic [4:0]  fwd_addr_out, rd_addr_mem_out;
    logic        rd_mem_out, bp_upd_valid_out, bp_upd_taken_out;
    logic [31:0] rd_val_mem_out, mem_addr_mem_out, mem_wdata_mem_out, bp_upd_pc_out;
    logic [5:0]  inst_type_mem_out;

    int checks = 0;
    int errors = 0;
    int flag_cnt = 0;

    // Expected EX/MEM contents
    logic        e_rd, e_bpv, e_bpt;
    logic [4:0]  e_ra;
    logic [5:0]  e_ty;
    logic [31:0] e_val, e_ma, e_wd, e_bpc;

    always #5 clk_in = ~clk_in;

    ex_stage #(.RESET_PC(RST_PC)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall(stall),
        .rs1_val_in(rs1_val_in), .rs2_val_in(rs2_val_in), .rd_in(rd_in),
        .rd_addr_in(rd_addr_in), .inst_type_in(inst_type_in), .imm_in(imm_in),
        .pc_in(pc_in), .loading_in(loading_in), .pre_to_take_in(pre_to_take_in),
        .branch_flag_out(branch_flag_out), .branch_target_out(branch_target_out),
        .fwd_we_out(fwd_we_out), .fwd_addr_out(fwd_addr_out),
        .fwd_data_out(fwd_data_out), .ex_loading_out(ex_loading_out),
        .rd_mem_out(rd_mem_out), .rd_addr_mem_out(rd_addr_mem_out),
        .rd_val_mem_out(rd_val_mem_out), .inst_type_mem_out(inst_type_mem_out),
        .mem_addr_mem_out(mem_addr_mem_out), .mem_wdata_mem_out(mem_wdata_mem_out),
        .bp_upd_valid_out(bp_upd_valid_out), .bp_upd_pc_out(bp_upd_pc_out),
        .bp_upd_taken_out(bp_upd_taken_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference semantics straight from the ISA rules
    task automatic ref_exec(input int t, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input logic [31:0] p,
                            output logic [31:0] res, output logic tk,
                            output logic [31:0] tg);
        int sa, sb, si;
        sa = a; sb = b; si = im;
        res = 0; tk = 0; tg = p + im;
        if (t == T_LUI) res = im;
        else if (t == T_AUIPC) res = p + im;
        else if (t == T_JAL) begin res = p + 4; tk = 1; end
        else if (t == T_JALR) begin
            res = p + 4; tk = 1; tg = (a + im) & 32'hFFFF_FFFE;
        end
        else if (t == T_BEQ)  tk = (a == b);
        else if (t == T_BNE)  tk = (a != b);
        else if (t == T_BLT)  tk = (sa < sb);
        else if (t == T_BGE)  tk = (sa >= sb);
        else if (t == T_BLTU) tk = (a < b);
        else if (t == T_BGEU) tk = (a >= b);
        else if (t >= T_LB && t <= T_SW) res = a + im;
        else if (t == T_ADDI)  res = a + im;
        else if (t == T_SLTI)  res = (sa < si) ? 1 : 0;
        else if (t == T_SLTIU) res = (a < im) ? 1 : 0;
        else if (t == T_XORI)  res = a ^ im;
        else if (t == T_ORI)   res = a | im;
        else if (t == T_ANDI)  res = a & im;
        else if (t == T_SLLI)  res = a << im[4:0];
        else if (t == T_SRLI)  res = a >> im[4:0];
        else if (t == T_SRAI)  res = sa >>> im[4:0];
        else if (t == T_ADD)   res = a + b;
        else if (t == T_SUB)   res = a - b;
        else if (t == T_SLL)   res = a << b[4:0];
        else if (t == T_SLT)   res = (sa < sb) ? 1 : 0;
        else if (t == T_SLTU)  res = (a < b) ? 1 : 0;
        else if (t == T_XOR)   res = a ^ b;
        else if (t == T_SRL)   res = a >> b[4:0];
        else if (t == T_SRA)   res = sa >>> b[4:0];
        else if (t == T_OR)    res = a | b;
        else if (t == T_AND)   res = a & b;
    endtask

    task automatic set_reset_model();
        e_rd = 0; e_ra = 0; e_val = 0; e_ty = T_NOP; e_ma = 0; e_wd = 0;
        e_bpv = 0; e_bpc = RST_PC; e_bpt = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".rd"},    {31'd0, rd_mem_out}, {31'd0, e_rd});
        chk({tag, ".ra"},    {27'd0, rd_addr_mem_out}, {27'd0, e_ra});
        chk({tag, ".val"},   rd_val_mem_out, e_val);
        chk({tag, ".type"},  {26'd0, inst_type_mem_out}, {26'd0, e_ty});
        chk({tag, ".maddr"}, mem_addr_mem_out, e_ma);
        chk({tag, ".wdata"}, mem_wdata_mem_out, e_wd);
        chk({tag, ".bpv"},   {31'd0, bp_upd_valid_out}, {31'd0, e_bpv});
        chk({tag, ".bppc"},  bp_upd_pc_out, e_bpc);
        chk({tag, ".bpt"},   {31'd0, bp_upd_taken_out}, {31'd0, e_bpt});
    endtask

    // Present one instruction for a cycle, check comb outputs, clock, check regs
    task automatic issue(input string tag, input int t, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] p, input logic rdv, input logic [4:0] ra,
                         input logic pre, input logic [5:0] st,
                         input logic rs, input logic rdy);
        logic [31:0] res, tg, etgt;
        logic tk, mis, flag, ld, st_t, br;
        ld = (t >= T_LB && t <= T_LHU);
        st_t = (t >= T_SB && t <= T_SW);
        br = (t >= T_BEQ && t <= T_BGEU);
        inst_type_in = 6'(t); rs1_val_in = a; rs2_val_in = b; imm_in = im;
        pc_in = p; rd_in = rdv; rd_addr_in = ra; pre_to_take_in = pre;
        stall = st; rst_in = rs; rdy_in = rdy; loading_in = ld;
        #1;
        ref_exec(t, a, b, im, p, res, tk, tg);
        mis = (t == T_JALR) || ((t == T_JAL || br) && tk != pre);
        flag = mis && !rs && rdy && !st[3] && t != T_NOP;
        etgt = !flag ? RST_PC : (tk ? tg : p + 4);
        chk({tag, ".flag"}, {31'd0, branch_flag_out}, {31'd0, flag});
        chk({tag, ".tgt"}, branch_target_out, etgt);
        chk({tag, ".fwe"}, {31'd0, fwd_we_out}, {31'd0, rdv && ra != 0 && !ld});
        chk({tag, ".fad"}, {27'd0, fwd_addr_out}, {27'd0, ra});
        chk({tag, ".fdat"}, fwd_data_out, res);
        chk({tag, ".eld"}, {31'd0, ex_loading_out}, {31'd0, ld});
        if (branch_flag_out) flag_cnt++;
        if (rs) set_reset_model();
        else if (!rdy) ;
        else if (st[3] && !st[4]) set_reset_model();
        else if (st[3]) ;
        else begin
            e_rd = rdv; e_ra = ra; e_val = res; e_ty = 6'(t);
            e_ma = (ld || st_t) ? a + im : 0;
            e_wd = st_t ? b : 0;
            e_bpv = (t == T_JAL) || br; e_bpc = p; e_bpt = tk;
        end
        @(posedge clk_in); #1;
        chk_regs(tag);
    endtask

    task automatic nop(input string tag);
        issue(tag, T_NOP, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 1);
    endtask

    initial begin
        set_reset_model();
        rst_in = 1; rdy_in = 1; stall = 0; rd_in = 0; rd_addr_in = 0;
        inst_type_in = T_NOP; rs1_val_in = 0; rs2_val_in = 0; imm_in = 0;
        pc_in = 0; loading_in = 0; pre_to_take_in = 0;
        @(posedge clk_in); #1;
        issue("rst", T_NOP, 0, 0, 0, 0, 0, 0, 0, 6'd0, 1, 1);
        chk("rst_bppc", bp_upd_pc_out, RST_PC);

        issue("add", T_ADD, 32'h7FFF_FFFF, 1, 0, 32'h40, 1, 5, 0, 6'd0, 0, 1);
        chk("add_val", rd_val_mem_out, 32'h8000_0000);
        chk("add_ra", {27'd0, rd_addr_mem_out}, 32'd5);

        issue("srai", T_SRAI, 32'h8000_0010, 0, 4, 32'h44, 1, 6, 0, 6'd0, 0, 1);
        chk("srai_val", rd_val_mem_out, 32'hF800_0001);
        issue("sltu", T_SLTU, 1, 32'hFFFF_FFFF, 0, 32'h48, 1, 7, 0, 6'd0, 0, 1);
        chk("sltu_val", rd_val_mem_out, 32'd1);

        issue("blt", T_BLT, 32'hFFFF_FFFF, 0, 16, 32'h100, 0, 0, 0, 6'd0, 0, 1);
        chk("blt_bpv", {31'd0, bp_upd_valid_out}, 32'd1);
        chk("blt_bpt", {31'd0, bp_upd_taken_out}, 32'd1);

        issue("jalr", T_JALR, 32'h1003, 0, 0, 32'h200, 1, 1, 0, 6'd0, 0, 1);
        chk("jalr_val", rd_val_mem_out, 32'h204);

        flag_cnt = 0;
        issue("bne_h1", T_BNE, 1, 2, 32'h20, 32'h300, 0, 0, 0, 6'b011111, 0, 1);
        issue("bne_h2", T_BNE, 1, 2, 32'h20, 32'h300, 0, 0, 0, 6'b011111, 0, 1);
        chk("hold_type", {26'd0, inst_type_mem_out}, {26'd0, T_JALR});
        issue("bne_go", T_BNE, 1, 2, 32'h20, 32'h300, 0, 0, 0, 6'd0, 0, 1);
        nop("bne_nop");
        chk("bne_once", flag_cnt, 1);

        issue("bne_b1", T_BNE, 3, 4, 32'h8, 32'h310, 0, 0, 0, 6'b001111, 0, 1);
        chk("bubble", {26'd0, inst_type_mem_out}, {26'd0, T_NOP});
        issue("bne_b2", T_BNE, 3, 4, 32'h8, 32'h310, 0, 0, 0, 6'b000111, 0, 1);

        issue("lw", T_LW, 32'h20, 0, 32'hFFFF_FFFC, 32'h400, 1, 9, 0, 6'd0, 0, 1);
        chk("lw_addr", mem_addr_mem_out, 32'h1C);
        issue("rdy0", T_ADD, 5, 6, 0, 32'h404, 1, 3, 0, 6'd0, 0, 0);
        issue("rst_st", T_ADD, 5, 6, 0, 32'h408, 1, 3, 0, 6'b011111, 1, 1);
        chk("rst_type", {26'd0, inst_type_mem_out}, {26'd0, T_NOP});

        for (int i = 0; i < 400; i++) begin
            int t, r;
            logic [31:0] a, b, im;
            logic [5:0] st;
            logic rdv;
            t = $urandom_range(0, 37);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            im = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 64));
            r = $urandom_range(0, 7);
            st = (r == 0) ? 6'b011111 : (r == 1) ? 6'b001111 :
                 (r == 2) ? 6'($urandom) : 6'd0;
            rdv = !((t >= T_BEQ && t <= T_BGEU) || (t >= T_SB && t <= T_SW) ||
                    t == T_NOP) && ($urandom_range(0, 7) != 0);
            issue("rnd", t, a, b, im, $urandom & 32'hFFFF_FFFC, rdv,
                  5'($urandom), 1'($urandom), st,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
